scr1_tcm_arb: RTL and testbench
===============================

# scr1_tcm_arb

Arbiter and sequencer for a single-port TCM shared between the core instruction and data interfaces. It accepts at most one request per cycle, drives the single-port memory, and returns one-cycle-latency responses on the owning interface. It also does byte-lane steering, alignment and range checks, and bounded-starvation fairness for instruction fetch. It sits between the core memory interfaces and `scr1_sp_memory`.

## Interface
Parameters:
- `SCR1_TCM_SIZE`, default `32'h00010000`: TCM size in bytes; power of two, at least 8.
- `STARVE_LIM`, default 4: maximum consecutive cycles an imem request may lose to dmem before imem is forced a grant. Value 0 gives strict dmem priority.

Ports:
- `clk`  in  1: the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req` in 1; `imem_cmd` in `type_scr1_mem_cmd_e`; `imem_addr` in `SCR1_IMEM_AWIDTH`: fetch request.
- `imem_req_ack`  out  1: fetch request accepted this cycle.
- `imem_rdata` out `SCR1_IMEM_DWIDTH`; `imem_resp` out `type_scr1_mem_resp_e`: fetch response.
- `dmem_req` in 1; `dmem_cmd` in `type_scr1_mem_cmd_e`; `dmem_width` in `type_scr1_mem_width_e`; `dmem_addr` in `SCR1_DMEM_AWIDTH`; `dmem_wdata` in 32: data request.
- `dmem_req_ack`  out  1: data request accepted this cycle.
- `dmem_rdata` out 32; `dmem_resp` out `type_scr1_mem_resp_e`: data response.
- `mem_rena` out 1; `mem_wena` out 1; `mem_be` out 4: memory read enable, write enable, byte enables.
- `mem_addr` out `$clog2(SCR1_TCM_SIZE)-2`; `mem_wdata` out 32: memory word address and write data.
- `mem_rdata`  in  32: memory read data, valid one cycle after `mem_rena`.

## Operation
- Grant is combinational and made each cycle.
  - If only one interface requests, it is granted.
  - If both request, dmem is granted unless `STARVE_LIM != 0` and `starve_cnt == STARVE_LIM`; then imem is granted.
- `starve_cnt`:
  - Increments when both interfaces request and dmem is granted.
  - Clears to 0 when imem is granted, or when `imem_req` is 0.
  - Saturates at `STARVE_LIM`.
- `*_req_ack` equals the grant for that interface. A request without ack is not accepted; the requester holds it.
- Each accepted request is checked for errors:
  - Address out of range: `addr >= SCR1_TCM_SIZE`.
  - imem misaligned: `imem_addr[1:0] != 0`.
  - dmem hword misaligned: `dmem_addr[0] == 1`.
  - dmem word misaligned: `dmem_addr[1:0] != 0`.
- An accepted request with any error still gets ack. It drives no memory enable, and its response is `SCR1_MEM_RESP_RDY_ER`.
- An accepted valid request drives the memory:
  - `mem_addr` = `addr[$clog2(SCR1_TCM_SIZE)-1:2]`.
  - Read: `mem_rena = 1`.
  - Write (dmem only): `mem_wena = 1`, `mem_be` and `mem_wdata` as below.
  - imem with `SCR1_MEM_CMD_WR`: treated as a read.
- Write byte lanes:
  - Byte: `be = 1<<addr[1:0]`, wdata = byte replicated ×4.
  - Hword: `be = 2'b11<<{addr[1],0}`, wdata = hword replicated ×2.
  - Word: `be = 4'hF`, wdata passed through.
- State machine (registered response phase). On acceptance the next state is `IRSP` or `DRSP`, or `IDLE` if nothing is accepted.
  - `IDLE`: no response outstanding.
  - `IRSP`: imem response this cycle.
  - `DRSP`: dmem response this cycle.
- Registered with the state at acceptance: `err_q`, `rd_q`, `off_q = dmem_addr[1:0]`.
- Response phase outputs:
  - `IRSP`: `imem_resp = err_q ? RDY_ER : RDY_OK`, `imem_rdata = mem_rdata`.
  - `DRSP`: `dmem_resp` likewise; for reads, `dmem_rdata = mem_rdata >> (8*off_q)`.
  - For writes and errors, `dmem_rdata` is don't-care.
  - A non-responding interface drives `SCR1_MEM_RESP_NOTRDY`.

## Timing
- Latency: request accepted in cycle N; response valid in cycle N+1 for exactly one cycle.
- Back-to-back acceptances are allowed every cycle, so throughput is one access per cycle.
- A new grant in cycle N+1 coexists with the cycle N response.
- Reset values:
  - State `IDLE`, `starve_cnt = 0`, `err_q = 0`, `rd_q = 0`, `off_q = 0`.
  - `imem_resp` and `dmem_resp` are `NOTRDY`.
  - Acks and `mem_*ena` follow requests combinationally. While `rst_n = 0`, all acks and enables are forced to 0.
- Reset asserted mid-response: the response is dropped and outputs are `NOTRDY` immediately (asynchronous).
- Simultaneous requests with `STARVE_LIM = 4` and both held high: grant sequence D,D,D,D,I, repeating.
- If dmem drops in the cycle the counter is saturated, imem is granted normally and the counter clears.

## Structure
- Use the existing memory types (`type_scr1_mem_cmd_e`, `_width_e`, `_resp_e`) from the shared memif definitions.
- Put the arbiter state enum `type_scr1_tcm_arb_st_e` (`IDLE`, `IRSP`, `DRSP`) in a shared `scr1_tcm_arb_pkg`.
- One sub-module, `scr1_tcm_lane_fmt`, is natural: combinational write replication, byte enable and read shift, reusable by other TCM clients.
- The memory itself stays outside this block.

## Test plan
- Single dmem word write: write `0xDEADBEEF` at `0x100`, then read it.
  - Write: ack in cycle N, `mem_wena = 1`, `be = F`; `RDY_OK` at N+1.
  - Read: `RDY_OK`, `dmem_rdata = 0xDEADBEEF`.
- Byte and hword lanes:
  - Byte write `0x5A` at `0x103`: `be = 4'b1000`, `mem_wdata = 0x5A5A5A5A`.
  - Following byte read at `0x103` returns `0x..5A` in `rdata[7:0]`.
- Contention: both requests held for 10 cycles with `STARVE_LIM = 4`.
  - Grants: D,D,D,D,I,D,D,D,D,I.
  - Each response lands on the correct interface one cycle later.
- Errors, each acked with `RDY_ER` and no memory enable:
  - dmem read at `0x00010000`.
  - dmem hword at `0x101`.
  - imem fetch at `0x2`.
- Back-to-back alternation: imem read `0x0` in cycle N, dmem read `0x4` in cycle N+1.
  - `imem_resp = OK` at N+1.
  - `dmem_resp = OK` at N+2.
  - The other interface is `NOTRDY` in each of those cycles.
- Reset mid-op: assert `rst_n = 0` in the response cycle of a read.
  - Responses go `NOTRDY` at once; state is `IDLE` after release.
  - The first request after reset is accepted normally.

Source files
------------

// File: rtl/scr1_tcm_arb_pkg.sv
// Shared types for the TCM arbiter: memory interface enums, widths, the
// arbiter state enum and the dmem alignment helper.
package scr1_tcm_arb_pkg;

    localparam int unsigned SCR1_IMEM_AWIDTH = 32;
    localparam int unsigned SCR1_IMEM_DWIDTH = 32;
    localparam int unsigned SCR1_DMEM_AWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IRSP = 2'b01,
        DRSP = 2'b10
    } type_scr1_tcm_arb_st_e;

    // Any width encoding other than byte/hword is held to word alignment.
    function automatic logic scr1_dmem_misaligned(type_scr1_mem_width_e width,
                                                  logic [1:0] addr_lo);
        case (width)
            SCR1_MEM_WIDTH_BYTE:  return 1'b0;
            SCR1_MEM_WIDTH_HWORD: return addr_lo[0];
            default:              return (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/scr1_tcm_lane_fmt.sv
// Byte-lane formatter: write data replication, byte enables and read shift.
module scr1_tcm_lane_fmt
    import scr1_tcm_arb_pkg::*;
(
    input  type_scr1_mem_width_e width,
    input  logic [1:0]           addr_lo,
    input  logic [31:0]          wdata,
    input  logic [1:0]           rd_off,
    input  logic [31:0]          rdata,
    output logic [3:0]           be,
    output logic [31:0]          wdata_rep,
    output logic [31:0]          rdata_shift
);

    // Replicate the write operand across all lanes and select the active ones.
    always_comb begin
        be        = 4'hF;
        wdata_rep = wdata;
        case (width)
            SCR1_MEM_WIDTH_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SCR1_MEM_WIDTH_HWORD: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'hF;
                wdata_rep = wdata;
            end
        endcase
    end

    // Move the addressed byte/hword down to bit 0.
    always_comb begin
        rdata_shift = rdata >> {rd_off, 3'b000};
    end

endmodule

// File: rtl/scr1_tcm_arb.sv
// Single-port TCM arbiter: imem/dmem grant with bounded imem starvation,
// error screening, memory drive and one-cycle registered response phase.
module scr1_tcm_arb
    import scr1_tcm_arb_pkg::*;
#(
    parameter int unsigned SCR1_TCM_SIZE = 32'h00010000,
    parameter int unsigned STARVE_LIM    = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                imem_req,
    input  type_scr1_mem_cmd_e                  imem_cmd,
    input  logic [SCR1_IMEM_AWIDTH-1:0]         imem_addr,
    output logic                                imem_req_ack,
    output logic [SCR1_IMEM_DWIDTH-1:0]         imem_rdata,
    output type_scr1_mem_resp_e                 imem_resp,
    input  logic                                dmem_req,
    input  type_scr1_mem_cmd_e                  dmem_cmd,
    input  type_scr1_mem_width_e                dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]         dmem_addr,
    input  logic [31:0]                         dmem_wdata,
    output logic                                dmem_req_ack,
    output logic [31:0]                         dmem_rdata,
    output type_scr1_mem_resp_e                 dmem_resp,
    output logic                                mem_rena,
    output logic                                mem_wena,
    output logic [3:0]                          mem_be,
    output logic [$clog2(SCR1_TCM_SIZE)-3:0]    mem_addr,
    output logic [31:0]                         mem_wdata,
    input  logic [31:0]                         mem_rdata
);

    localparam int unsigned TCM_AW   = $clog2(SCR1_TCM_SIZE);
    localparam int unsigned CNT_W    = (STARVE_LIM < 2) ? 1 : $clog2(STARVE_LIM + 1);
    localparam bit          STARVE_EN = (STARVE_LIM != 0);

    type_scr1_tcm_arb_st_e state;
    logic [CNT_W-1:0]      starve_cnt;
    logic [CNT_W-1:0]      starve_cnt_next;
    logic                  err_q;
    logic                  rd_q;
    logic [1:0]            off_q;

    logic        starve_sat;
    logic        gnt_imem;
    logic        gnt_dmem;
    logic        accept;
    logic        imem_err;
    logic        dmem_err;
    logic        sel_err;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // Fetch never writes: imem_cmd is deliberately ignored.
    logic unused_imem_cmd;
    assign unused_imem_cmd = imem_cmd;

    // Grant: dmem wins contention until imem has lost STARVE_LIM times in a row.
    always_comb begin
        starve_sat = (starve_cnt == CNT_W'(STARVE_LIM));
        gnt_dmem   = dmem_req && !(imem_req && STARVE_EN && starve_sat);
        gnt_imem   = imem_req && !gnt_dmem;
        accept     = gnt_imem || gnt_dmem;
    end

    // Starvation counter next state; saturates at the limit.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!imem_req || gnt_imem) begin
            starve_cnt_next = '0;
        end else if (dmem_req && gnt_dmem && !starve_sat) begin
            starve_cnt_next = starve_cnt + 1'b1;
        end
    end

    // Request screening and selection of the granted request.
    always_comb begin
        imem_err = (imem_addr >= SCR1_TCM_SIZE) || (imem_addr[1:0] != 2'b00);
        dmem_err = (dmem_addr >= SCR1_TCM_SIZE)
                || scr1_dmem_misaligned(dmem_width, dmem_addr[1:0]);
        sel_addr = gnt_imem ? imem_addr : dmem_addr;
        sel_err  = gnt_imem ? imem_err : dmem_err;
        sel_wr   = gnt_dmem && (dmem_cmd == SCR1_MEM_CMD_WR);
    end

    scr1_tcm_lane_fmt u_lane_fmt (
        .width       (dmem_width),
        .addr_lo     (dmem_addr[1:0]),
        .wdata       (dmem_wdata),
        .rd_off      (off_q),
        .rdata       (mem_rdata),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_shift (lane_rdata)
    );

    // Acks and memory strobes; all forced low while reset is held.
    always_comb begin
        imem_req_ack = rst_n && gnt_imem;
        dmem_req_ack = rst_n && gnt_dmem;
        mem_rena     = rst_n && accept && !sel_err && !sel_wr;
        mem_wena     = rst_n && sel_wr && !sel_err;
        mem_be       = mem_wena ? lane_be : 4'h0;
        mem_addr     = sel_addr[TCM_AW-1:2];
        mem_wdata    = lane_wdata;
    end

    // Response-phase FSM plus the context captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
            rd_q       <= 1'b0;
            off_q      <= 2'b00;
        end else begin
            starve_cnt <= starve_cnt_next;
            if (gnt_imem) begin
                state <= IRSP;
            end else if (gnt_dmem) begin
                state <= DRSP;
            end else begin
                state <= IDLE;
            end
            if (accept) begin
                err_q <= sel_err;
                rd_q  <= !sel_wr;
                off_q <= dmem_addr[1:0];
            end
        end
    end

    // Response decode; the idle side always reports NOTRDY.
    always_comb begin
        imem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        imem_rdata = mem_rdata;
        dmem_rdata = rd_q ? lane_rdata : 32'h0;
        if (rst_n) begin
            case (state)
                IRSP:    imem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                DRSP:    dmem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_tcm_arb.sv
// Directed self-checking bench for scr1_tcm_arb with a behavioural TCM.
module tb_scr1_tcm_arb;
    import scr1_tcm_arb_pkg::*;

    logic                 clk;
    logic                 rst_n;
    logic                 imem_req;
    type_scr1_mem_cmd_e   imem_cmd;
    logic [31:0]          imem_addr;
    logic                 imem_req_ack;
    logic [31:0]          imem_rdata;
    type_scr1_mem_resp_e  imem_resp;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr;
    logic [31:0]          dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata;
    type_scr1_mem_resp_e  dmem_resp;
    logic                 mem_rena;
    logic                 mem_wena;
    logic [3:0]           mem_be;
    logic [13:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic [31:0]          mem_rdata;

    int checks;
    int failures;

    scr1_tcm_arb #(
        .SCR1_TCM_SIZE (32'h00010000),
        .STARVE_LIM    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_rena     (mem_rena),
        .mem_wena     (mem_wena),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory, one-cycle read latency.
    logic [31:0] tcm [0:16383];
    initial begin
        for (int w = 0; w < 16384; w++) tcm[w] = 32'h0;
        tcm[0] = 32'h00000013;
        tcm[1] = 32'hCAFEF00D;
        mem_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (mem_wena) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) tcm[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_rena) mem_rdata <= tcm[mem_addr];
    end

    task automatic idle();
        imem_req = 1'b0;
        dmem_req = 1'b0;
    endtask

    task automatic set_dmem(input type_scr1_mem_cmd_e cmd, input type_scr1_mem_width_e width,
                            input logic [31:0] addr, input logic [31:0] wdata);
        dmem_req   = 1'b1;
        dmem_cmd   = cmd;
        dmem_width = width;
        dmem_addr  = addr;
        dmem_wdata = wdata;
    endtask

    task automatic set_imem(input logic [31:0] addr);
        imem_req  = 1'b1;
        imem_cmd  = SCR1_MEM_CMD_RD;
        imem_addr = addr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_imem(32'h0);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
        #1;
        checks++;
        if ({imem_req_ack, dmem_req_ack, mem_rena, mem_wena} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0000",
                     {imem_req_ack, dmem_req_ack, mem_rena, mem_wena});
        end
        checks++;
        if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL reset_resp got=%0d/%0d exp=0/0", imem_resp, dmem_resp);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL post_reset_idle got=%0d/%0d exp=0/0", imem_resp, dmem_resp);
        end
    endtask

    task automatic test_word();
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEADBEEF);
        #1;
        checks++;
        if ({dmem_req_ack, mem_rena, mem_wena, mem_be} !== 7'b1_0_1_1111) begin
            failures++;
            $display("FAIL word_wr_strobes got=%b exp=1011111",
                     {dmem_req_ack, mem_rena, mem_wena, mem_be});
        end
        checks++;
        if (mem_addr !== 14'h40 || mem_wdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_wr_bus got=%h/%h exp=0040/deadbeef", mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL word_wr_resp got=%0d/%0d exp=1/0", dmem_resp, imem_resp);
        end
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        #1;
        checks++;
        if ({dmem_req_ack, mem_rena, mem_wena} !== 3'b110) begin
            failures++;
            $display("FAIL word_rd_strobes got=%b exp=110", {dmem_req_ack, mem_rena, mem_wena});
        end
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_rd_resp got=%0d/%h exp=1/deadbeef", dmem_resp, dmem_rdata);
        end
        idle();
    endtask

    task automatic test_lanes();
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0000005A);
        #1;
        checks++;
        if (mem_wena !== 1'b1 || mem_be !== 4'b1000 || mem_wdata !== 32'h5A5A5A5A) begin
            failures++;
            $display("FAIL byte_wr got=%b/%b/%h exp=1/1000/5a5a5a5a", mem_wena, mem_be, mem_wdata);
        end
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_rdata[7:0] !== 8'h5A) begin
            failures++;
            $display("FAIL byte_rd got=%0d/%h exp=1/5a", dmem_resp, dmem_rdata[7:0]);
        end
        set_dmem(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'hFFFF1234);
        #1;
        checks++;
        if (mem_wena !== 1'b1 || mem_be !== 4'b1100 || mem_wdata !== 32'h12341234) begin
            failures++;
            $display("FAIL hword_wr got=%b/%b/%h exp=1/1100/12341234", mem_wena, mem_be, mem_wdata);
        end
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h101, 32'h00000077);
        #1;
        checks++;
        if (mem_be !== 4'b0010 || mem_wdata !== 32'h77777777) begin
            failures++;
            $display("FAIL byte1_wr got=%b/%h exp=0010/77777777", mem_be, mem_wdata);
        end
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_rdata !== 32'h123477EF) begin
            failures++;
            $display("FAIL lanes_merge got=%h exp=123477ef", dmem_rdata);
        end
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'h0);
        @(negedge clk);
        checks++;
        if (dmem_rdata[15:0] !== 16'h1234) begin
            failures++;
            $display("FAIL hword_rd got=%h exp=1234", dmem_rdata[15:0]);
        end
        idle();
    endtask

    task automatic test_errors();
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h00010000, 32'h0);
        #1;
        checks++;
        if ({dmem_req_ack, mem_rena, mem_wena} !== 3'b100) begin
            failures++;
            $display("FAIL err_range_strobes got=%b exp=100", {dmem_req_ack, mem_rena, mem_wena});
        end
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_ER) begin
            failures++;
            $display("FAIL err_range_resp got=%0d exp=2", dmem_resp);
        end
        set_dmem(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h101, 32'h0000ABCD);
        #1;
        checks++;
        if ({dmem_req_ack, mem_rena, mem_wena} !== 3'b100) begin
            failures++;
            $display("FAIL err_hword_strobes got=%b exp=100", {dmem_req_ack, mem_rena, mem_wena});
        end
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_ER) begin
            failures++;
            $display("FAIL err_hword_resp got=%0d exp=2", dmem_resp);
        end
        idle();
        set_imem(32'h2);
        #1;
        checks++;
        if ({imem_req_ack, mem_rena, mem_wena} !== 3'b100) begin
            failures++;
            $display("FAIL err_imem_strobes got=%b exp=100", {imem_req_ack, mem_rena, mem_wena});
        end
        @(negedge clk);
        checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_ER || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL err_imem_resp got=%0d/%0d exp=2/0", imem_resp, dmem_resp);
        end
        idle();
    endtask

    task automatic test_contention();
        logic [9:0] exp_igrant;
        type_scr1_mem_resp_e exp_i;
        type_scr1_mem_resp_e exp_d;
        exp_igrant = 10'b10_0001_0000;
        @(negedge clk);
        set_imem(32'h0);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (imem_req_ack !== exp_igrant[i] || dmem_req_ack !== !exp_igrant[i]) begin
                failures++;
                $display("FAIL contention_grant[%0d] got=i%b/d%b exp=i%b", i,
                         imem_req_ack, dmem_req_ack, exp_igrant[i]);
            end
            @(negedge clk);
            exp_i = exp_igrant[i] ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
            exp_d = exp_igrant[i] ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK;
            checks++;
            if (imem_resp !== exp_i || dmem_resp !== exp_d) begin
                failures++;
                $display("FAIL contention_resp[%0d] got=%0d/%0d exp=%0d/%0d", i,
                         imem_resp, dmem_resp, exp_i, exp_d);
            end
        end
        idle();
    endtask

    task automatic test_starve_clear();
        logic [8:0] exp_igrant;
        exp_igrant = 9'b1_0000_1000;
        @(negedge clk);
        set_imem(32'h0);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) dmem_req = 1'b0;
            else set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
            #1;
            checks++;
            if (imem_req_ack !== exp_igrant[i]) begin
                failures++;
                $display("FAIL starve_clear_grant[%0d] got=%b exp=%b", i,
                         imem_req_ack, exp_igrant[i]);
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_imem(32'h0);
        #1;
        checks++;
        if (imem_req_ack !== 1'b1 || mem_rena !== 1'b1 || mem_addr !== 14'h0) begin
            failures++;
            $display("FAIL b2b_imem_req got=%b/%b/%h exp=1/1/0000", imem_req_ack, mem_rena, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_resp !== SCR1_MEM_RESP_NOTRDY ||
            imem_rdata !== 32'h00000013) begin
            failures++;
            $display("FAIL b2b_imem_resp got=%0d/%0d/%h exp=1/0/00000013",
                     imem_resp, dmem_resp, imem_rdata);
        end
        imem_req = 1'b0;
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
        #1;
        checks++;
        if (dmem_req_ack !== 1'b1 || mem_addr !== 14'h1) begin
            failures++;
            $display("FAIL b2b_dmem_req got=%b/%h exp=1/0001", dmem_req_ack, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || imem_resp !== SCR1_MEM_RESP_NOTRDY ||
            dmem_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_dmem_resp got=%0d/%0d/%h exp=1/0/cafef00d",
                     dmem_resp, imem_resp, dmem_rdata);
        end
        idle();
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        set_dmem(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
        @(posedge clk);
        #1;
        idle();
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_RDY_OK) begin
            failures++;
            $display("FAIL midop_before got=%0d exp=1", dmem_resp);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_NOTRDY || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL midop_async got=%0d/%0d exp=0/0", dmem_resp, imem_resp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dmem_resp !== SCR1_MEM_RESP_NOTRDY || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin
            failures++;
            $display("FAIL midop_idle got=%0d/%0d exp=0/0", dmem_resp, imem_resp);
        end
        set_imem(32'h0);
        #1;
        checks++;
        if (imem_req_ack !== 1'b1 || mem_rena !== 1'b1) begin
            failures++;
            $display("FAIL midop_first_req got=%b/%b exp=1/1", imem_req_ack, mem_rena);
        end
        @(negedge clk);
        checks++;
        if (imem_resp !== SCR1_MEM_RESP_RDY_OK || imem_rdata !== 32'h00000013) begin
            failures++;
            $display("FAIL midop_first_resp got=%0d/%h exp=1/00000013", imem_resp, imem_rdata);
        end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        imem_req   = 1'b0;
        imem_cmd   = SCR1_MEM_CMD_RD;
        imem_addr  = 32'h0;
        dmem_req   = 1'b0;
        dmem_cmd   = SCR1_MEM_CMD_RD;
        dmem_width = SCR1_MEM_WIDTH_WORD;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_contention();
        test_starve_clear();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
